// File: rtl/addsub_pipe.sv
// Pipelined carry-lookahead add/subtract unit with ARM NZCV flags.
// One BLOCK-bit slice resolves per stage; the carry is registered between slices.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int TOP  = WIDTH - BLOCK;

  // Carries written as the generate/propagate recurrence; synthesis flattens it into lookahead logic.
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = op[1] ? ~b : b;
  assign cin      = op[0] ? c_in : op[1];

  logic             lst_vld;
  logic             lst_c;
  logic [BLOCK-1:0] lst_a;
  logic [BLOCK-1:0] lst_b;
  logic [WIDTH-1:0] lst_sum;

  if (NBLK > 1) begin : g_mid
    localparam int NM = NBLK - 1;

    logic [NM-1:0]    vld_q;
    logic [NM-1:0]    vld_d;
    logic [NM-1:0]    c_q;
    logic [NM-1:0]    c_d;
    logic [WIDTH-1:0] a_q   [NM];
    logic [WIDTH-1:0] a_d   [NM];
    logic [WIDTH-1:0] b_q   [NM];
    logic [WIDTH-1:0] b_d   [NM];
    logic [WIDTH-1:0] sum_q [NM];
    logic [WIDTH-1:0] sum_d [NM];

    // Stage k: resolve slice k, forward the carry and the still-unprocessed operand bits.
    always_comb begin
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] ss;
      logic             sc;
      logic             sv;
      logic [BLOCK:0]   r;
      sa    = '0;
      sb    = '0;
      ss    = '0;
      sc    = 1'b0;
      sv    = 1'b0;
      r     = '0;
      vld_d = '0;
      c_d   = '0;
      for (int k = 0; k < NM; k++) begin
        a_d[k]   = '0;
        b_d[k]   = '0;
        sum_d[k] = '0;
      end
      for (int k = 0; k < NM; k++) begin
        if (k == 0) begin
          sa = a;
          sb = b_eff;
          ss = '0;
          sc = cin;
          sv = in_valid;
        end else begin
          sa = a_q[k-1];
          sb = b_q[k-1];
          ss = sum_q[k-1];
          sc = c_q[k-1];
          sv = vld_q[k-1];
        end
        r = cla_slice(sa[k*BLOCK +: BLOCK], sb[k*BLOCK +: BLOCK], sc);
        ss[k*BLOCK +: BLOCK] = r[BLOCK-1:0];
        a_d[k]   = sa;
        b_d[k]   = sb;
        sum_d[k] = ss;
        c_d[k]   = r[BLOCK];
        vld_d[k] = sv;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (advance) begin
        vld_q <= vld_d;
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sum_q <= sum_d;
        c_q   <= c_d;
      end
    end

    assign lst_vld = vld_q[NM-1];
    assign lst_c   = c_q[NM-1];
    assign lst_a   = a_q[NM-1][TOP +: BLOCK];
    assign lst_b   = b_q[NM-1][TOP +: BLOCK];
    assign lst_sum = sum_q[NM-1];
  end else begin : g_one
    assign lst_vld = in_valid;
    assign lst_c   = cin;
    assign lst_a   = a[TOP +: BLOCK];
    assign lst_b   = b_eff[TOP +: BLOCK];
    assign lst_sum = '0;
  end

  // Final stage: top slice plus flags into the output register.
  logic [BLOCK:0]   top_r;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       nzcv_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       nzcv_q;
  logic             out_valid_q;

  always_comb begin
    top_r    = cla_slice(lst_a, lst_b, lst_c);
    result_d = lst_sum;
    result_d[TOP +: BLOCK] = top_r[BLOCK-1:0];
    nzcv_d[3] = result_d[WIDTH-1];
    nzcv_d[2] = ~|result_d;
    nzcv_d[1] = top_r[BLOCK];
    nzcv_d[0] = (lst_a[BLOCK-1] == lst_b[BLOCK-1]) && (result_d[WIDTH-1] != lst_a[BLOCK-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nzcv_q      <= '0;
    end else if (advance) begin
      out_valid_q <= lst_vld;
      if (lst_vld) begin
        result_q <= result_d;
        nzcv_q   <= nzcv_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_n    = nzcv_q[3];
  assign flag_z    = nzcv_q[2];
  assign flag_c    = nzcv_q[1];
  assign flag_v    = nzcv_q[0];

endmodule
